// File: rtl/swipt_pkg.sv
// Shared types and constants for the SWIPT FSK transmit path.
package swipt_pkg;

  localparam int FREQ_W = 32;
  localparam logic [31:0] FREQ_DEFAULT = 32'h0000_9470;

  typedef enum logic [2:0] {
    FSK_IDLE  = 3'd0,
    FSK_PRE   = 3'd1,
    FSK_START = 3'd2,
    FSK_DATA  = 3'd3,
    FSK_PAR   = 3'd4,
    FSK_STOP  = 3'd5
  } fsk_state_t;

  // Even parity over one data byte.
  function automatic logic parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/swipt_bit_timer.sv
// Symbol timer: counts BIT_CYCLES-1 down to 0 and flags the last cycle of each symbol.
module swipt_bit_timer #(
  parameter int BIT_CYCLES = 25000
) (
  input  logic clk,
  input  logic nrst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] ZERO = CW'(0);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // Reload on restart or at the end of a symbol, otherwise count down.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= LOAD;
    end else if (restart || (count == ZERO)) begin
      count <= LOAD;
    end else begin
      count <= count - ONE;
    end
  end

  assign tick = (count == ZERO);

endmodule

// File: rtl/swipt_fsk_mod.sv
// FSK modulator for the SWIPT bridge frequency word: preamble, start, 8 data bits LSB first,
// optional even parity (define SWIPT_FSK_PARITY_EN), stop. Passes freq_base through when idle.
module swipt_fsk_mod #(
  parameter int BIT_CYCLES    = 25000,
  parameter int PREAMBLE_BITS = 8,
  parameter int FREQ_W        = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              swiptAlive,
  input  logic [FREQ_W-1:0] freq_base,
  input  logic [FREQ_W-1:0] freq_dev,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [FREQ_W-1:0] freq_out,
  output logic              tx_bit,
  output logic              busy
);

  import swipt_pkg::*;

  localparam int CNT_W = (PREAMBLE_BITS > 8) ? $clog2(PREAMBLE_BITS) : 3;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(7);

  fsk_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [7:0]        shreg;
  logic [FREQ_W-1:0] mark, space;
  logic [FREQ_W-1:0] mark_calc, space_calc;
  logic [FREQ_W:0]   sum, diff;
  logic              ready_en;
  logic              tick;
  logic              restart;
  logic              accept;
`ifdef SWIPT_FSK_PARITY_EN
  logic              par;
`endif

  function automatic logic [FREQ_W-1:0] sym_freq(input logic s, input logic [FREQ_W-1:0] m,
                                                 input logic [FREQ_W-1:0] sp);
    return s ? m : sp;
  endfunction

  // Saturating mark/space words from the live carrier and deviation.
  always_comb begin
    sum        = {1'b0, freq_base} + {1'b0, freq_dev};
    diff       = {1'b0, freq_base} - {1'b0, freq_dev};
    mark_calc  = sum[FREQ_W]  ? {FREQ_W{1'b1}} : sum[FREQ_W-1:0];
    space_calc = diff[FREQ_W] ? {FREQ_W{1'b0}} : diff[FREQ_W-1:0];
  end

  // ready_en keeps data_ready low while nrst is asserted without gating logic on the reset net.
  assign data_ready = ready_en && swiptAlive &&
                      ((state == FSK_IDLE) || ((state == FSK_STOP) && tick));
  assign accept     = data_valid && data_ready;
  assign restart    = (state == FSK_IDLE) || !swiptAlive;

  swipt_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk    (clk),
    .nrst   (nrst),
    .restart(restart),
    .tick   (tick)
  );

  // Frame sequencer with registered frequency word, symbol and busy outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= FSK_IDLE;
      bit_cnt  <= CNT_ZERO;
      shreg    <= 8'h00;
      mark     <= {FREQ_W{1'b0}};
      space    <= {FREQ_W{1'b0}};
      freq_out <= {FREQ_W{1'b0}};
      tx_bit   <= 1'b1;
      busy     <= 1'b0;
      ready_en <= 1'b0;
`ifdef SWIPT_FSK_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      if (!swiptAlive) begin
        state    <= FSK_IDLE;
        bit_cnt  <= CNT_ZERO;
        freq_out <= freq_base;
        tx_bit   <= 1'b1;
        busy     <= 1'b0;
      end else begin
        case (state)
          FSK_IDLE: begin
            bit_cnt <= CNT_ZERO;
            if (accept) begin
              state    <= FSK_PRE;
              shreg    <= data_in;
              mark     <= mark_calc;
              space    <= space_calc;
              freq_out <= mark_calc;
              tx_bit   <= 1'b1;
              busy     <= 1'b1;
`ifdef SWIPT_FSK_PARITY_EN
              par      <= parity8(data_in);
`endif
            end else begin
              freq_out <= freq_base;
              tx_bit   <= 1'b1;
              busy     <= 1'b0;
            end
          end
          FSK_PRE: begin
            if (tick) begin
              if (bit_cnt == PRE_LAST) begin
                state    <= FSK_START;
                bit_cnt  <= CNT_ZERO;
                tx_bit   <= 1'b0;
                freq_out <= space;
              end else begin
                bit_cnt  <= bit_cnt + CNT_ONE;
                tx_bit   <= ~tx_bit;
                freq_out <= sym_freq(~tx_bit, mark, space);
              end
            end
          end
          FSK_START: begin
            if (tick) begin
              state    <= FSK_DATA;
              bit_cnt  <= CNT_ZERO;
              tx_bit   <= shreg[0];
              freq_out <= sym_freq(shreg[0], mark, space);
            end
          end
          FSK_DATA: begin
            if (tick) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt  <= CNT_ZERO;
`ifdef SWIPT_FSK_PARITY_EN
                state    <= FSK_PAR;
                tx_bit   <= par;
                freq_out <= sym_freq(par, mark, space);
`else
                state    <= FSK_STOP;
                tx_bit   <= 1'b1;
                freq_out <= mark;
`endif
              end else begin
                bit_cnt  <= bit_cnt + CNT_ONE;
                shreg    <= {1'b0, shreg[7:1]};
                tx_bit   <= shreg[1];
                freq_out <= sym_freq(shreg[1], mark, space);
              end
            end
          end
          FSK_PAR: begin
            if (tick) begin
              state    <= FSK_STOP;
              bit_cnt  <= CNT_ZERO;
              tx_bit   <= 1'b1;
              freq_out <= mark;
            end
          end
          FSK_STOP: begin
            if (tick) begin
              bit_cnt <= CNT_ZERO;
              if (accept) begin
                // Back-to-back byte: straight into START, no preamble.
                state    <= FSK_START;
                shreg    <= data_in;
                mark     <= mark_calc;
                space    <= space_calc;
                freq_out <= space_calc;
                tx_bit   <= 1'b0;
`ifdef SWIPT_FSK_PARITY_EN
                par      <= parity8(data_in);
`endif
              end else begin
                state    <= FSK_IDLE;
                freq_out <= freq_base;
                tx_bit   <= 1'b1;
                busy     <= 1'b0;
              end
            end
          end
          default: begin
            state    <= FSK_IDLE;
            bit_cnt  <= CNT_ZERO;
            freq_out <= freq_base;
            tx_bit   <= 1'b1;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swipt_fsk_mod.sv
// Directed self-checking bench for swipt_fsk_mod (BIT_CYCLES=4, PREAMBLE_BITS=2).
module tb_swipt_fsk_mod;

  localparam int BC = 4;
  localparam int PB = 2;

  logic        clk = 1'b0;
  logic        nrst, swiptAlive, data_valid;
  logic [31:0] freq_base, freq_dev, freq_out;
  logic [7:0]  data_in;
  logic        data_ready, tx_bit, busy;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_sym [0:31];
  int   exp_n;

  always #5 clk = ~clk;

  swipt_fsk_mod #(.BIT_CYCLES(BC), .PREAMBLE_BITS(PB), .FREQ_W(32)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .swiptAlive(swiptAlive),
    .freq_base (freq_base),
    .freq_dev  (freq_dev),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .freq_out  (freq_out),
    .tx_bit    (tx_bit),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected symbol sequence of one frame.
  task automatic build(input logic [7:0] b, input bit with_pre);
    exp_n = 0;
    if (with_pre)
      for (int i = 0; i < PB; i++) begin
        exp_sym[exp_n] = ((i % 2) == 0);
        exp_n++;
      end
    exp_sym[exp_n] = 1'b0;
    exp_n++;
    for (int i = 0; i < 8; i++) begin
      exp_sym[exp_n] = b[i];
      exp_n++;
    end
`ifdef SWIPT_FSK_PARITY_EN
    exp_sym[exp_n] = ^b;
    exp_n++;
`endif
    exp_sym[exp_n] = 1'b1;
    exp_n++;
  endtask

  // Called at the negedge of the first frame cycle; returns at the negedge of the last one.
  task automatic check_frame(input logic [31:0] mark, input logic [31:0] space);
    for (int c = 0; c < exp_n * BC; c++) begin
      if (c > 0) @(negedge clk);
      check_val("tx_bit", {31'd0, tx_bit}, {31'd0, exp_sym[c / BC]});
      check_val("freq_out", freq_out, exp_sym[c / BC] ? mark : space);
      check_val("busy", {31'd0, busy}, 32'd1);
      check_val("data_ready", {31'd0, data_ready}, (c == exp_n * BC - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_idle(input logic [31:0] base);
    check_val("idle_busy", {31'd0, busy}, 32'd0);
    check_val("idle_tx", {31'd0, tx_bit}, 32'd1);
    check_val("idle_freq", freq_out, base);
    check_val("idle_ready", {31'd0, data_ready}, 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input logic [31:0] base, input logic [31:0] dev,
                      input logic [31:0] mark, input logic [31:0] space);
    freq_base  = base;
    freq_dev   = dev;
    data_in    = b;
    data_valid = 1'b1;
    #1;
    check_val("send_ready", {31'd0, data_ready}, 32'd1);
    @(negedge clk);
    data_valid = 1'b0;
    build(b, 1'b1);
    check_frame(mark, space);
    @(negedge clk);
    check_idle(base);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst       = 1'b0;
    swiptAlive = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    freq_base  = 32'h0000_9470;
    freq_dev   = 32'h0000_0000;
    repeat (2) @(negedge clk);
    check_val("rst_freq", freq_out, 32'h0);
    check_val("rst_tx", {31'd0, tx_bit}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ready", {31'd0, data_ready}, 32'd0);
    swiptAlive = 1'b1;
    nrst       = 1'b1;
    @(negedge clk);
    check_idle(32'h0000_9470);

    // One-cycle pass-through latency in IDLE
    freq_base = 32'h0000_9500;
    #1;
    check_val("lat_old", freq_out, 32'h0000_9470);
    @(negedge clk);
    check_val("lat_new", freq_out, 32'h0000_9500);

    send(8'hA5, 32'h0000_9470, 32'h0000_01F4, 32'h0000_9664, 32'h0000_927C);
    send(8'h55, 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0000);
    send(8'h55, 32'hFFFF_FF00, 32'h0000_0200, 32'hFFFF_FFFF, 32'hFFFF_FD00);
`ifdef SWIPT_FSK_PARITY_EN
    send(8'h07, 32'h0000_9470, 32'h0000_01F4, 32'h0000_9664, 32'h0000_927C);
    send(8'h03, 32'h0000_9470, 32'h0000_01F4, 32'h0000_9664, 32'h0000_927C);
`endif

    // Back-to-back frames with data_valid held
    freq_base  = 32'h0000_9470;
    freq_dev   = 32'h0000_01F4;
    data_in    = 8'h01;
    data_valid = 1'b1;
    @(negedge clk);
    data_in = 8'h80;
    build(8'h01, 1'b1);
    check_frame(32'h0000_9664, 32'h0000_927C);
    @(negedge clk);
    data_valid = 1'b0;
    build(8'h80, 1'b0);
    check_frame(32'h0000_9664, 32'h0000_927C);
    @(negedge clk);
    check_idle(32'h0000_9470);

    // Abort during DATA bit 3 (symbol 6 of 0xA5, value 0)
    data_in    = 8'hA5;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (25) @(negedge clk);
    check_val("abort_pre_tx", {31'd0, tx_bit}, 32'd0);
    check_val("abort_pre_busy", {31'd0, busy}, 32'd1);
    swiptAlive = 1'b0;
    freq_base  = 32'h0000_9500;
    @(negedge clk);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_tx", {31'd0, tx_bit}, 32'd1);
    check_val("abort_freq", freq_out, 32'h0000_9500);
    check_val("abort_ready", {31'd0, data_ready}, 32'd0);
    data_in    = 8'h33;
    data_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("dead_ready", {31'd0, data_ready}, 32'd0);
      check_val("dead_busy", {31'd0, busy}, 32'd0);
    end
    swiptAlive = 1'b1;
    #1;
    check_val("alive_ready", {31'd0, data_ready}, 32'd1);
    @(negedge clk);
    data_valid = 1'b0;
    check_val("restart_busy", {31'd0, busy}, 32'd1);
    check_val("restart_tx", {31'd0, tx_bit}, 32'd1);
    check_val("restart_freq", freq_out, 32'h0000_96F4);

    // Asynchronous reset between clock edges
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check_val("arst_freq", freq_out, 32'h0);
    check_val("arst_tx", {31'd0, tx_bit}, 32'd1);
    check_val("arst_ready", {31'd0, data_ready}, 32'd0);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check_val("post_rst_freq", freq_out, 32'h0000_9500);
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
